seven_segment_mux: RTL and testbench

//  Time-multiplexed N-digit seven-segment driver; generalises the 4-digit driver to NUM_DIGITS.

---
 rtl/seven_segment_pkg.sv | 32 +++
 rtl/seven_segment_decoder.sv | 18 +
 rtl/seven_segment_mux.sv | 121 ++++++++++++
 tb/tb_seven_segment_mux.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types, constants and the hex-to-glyph table for the multiplexed seven-segment driver.
package seven_segment_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [3:0] brightness_t;

  // Active-low glyphs, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    logic [6:0] glyph;
    case (nibble)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Registered nibble + decimal point to active-low segment pattern; dark when not enabled.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segment
);

  always_ff @(posedge clk) begin
    if (rst || !enable) segment <= SEG_OFF;
    else                segment <= {~dp, hex7(nibble)};
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit seven-segment driver with 16-level per-slot anode PWM.
// Optional per-digit blinking is compiled in with SSD_BLINK_EN.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int REFRESH_RATE  = 200,
  parameter int BLINK_RATE    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
`ifdef SSD_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink,
`endif
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   anode
);

  localparam int SEGMENT_CLOCKS = CLK_FREQUENCY / (REFRESH_RATE * NUM_DIGITS);
  localparam int PHASE_CLOCKS   = SEGMENT_CLOCKS / 16;
  localparam int SLOT_W         = $clog2(SEGMENT_CLOCKS);
  localparam int IDX_W          = $clog2(NUM_DIGITS);
  localparam int PH_W           = (PHASE_CLOCKS > 1) ? $clog2(PHASE_CLOCKS) : 1;

  if (SEGMENT_CLOCKS < 16) begin : g_bad_segment_clocks
    $error("seven_segment_mux: SEGMENT_CLOCKS must be >= 16");
  end
  if (NUM_DIGITS < 2) begin : g_bad_num_digits
    $error("seven_segment_mux: NUM_DIGITS must be >= 2");
  end
  if (BLINK_RATE < 1) begin : g_bad_blink_rate
    $error("seven_segment_mux: BLINK_RATE must be >= 1");
  end

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  brightness_t       bright_q;
  logic [3:0]        phase;
  logic [PH_W-1:0]   ph_cnt;
  logic              dark;
  logic              lit;

  // Phase is tracked with its own counter instead of dividing slot_cnt by PHASE_CLOCKS;
  // it freezes at 15 so any remainder of the slot stays in the last phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= '0;
      bright_q <= 4'hF;
      phase    <= '0;
      ph_cnt   <= '0;
    end else begin
      if (slot_cnt == SLOT_W'(SEGMENT_CLOCKS - 1)) begin
        slot_cnt <= '0;
        phase    <= '0;
        ph_cnt   <= '0;
        idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
        if (phase != 4'hF) begin
          if (ph_cnt == PH_W'(PHASE_CLOCKS - 1)) begin
            ph_cnt <= '0;
            phase  <= phase + 4'd1;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
      end
      if (slot_cnt == '0) bright_q <= brightness;
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BLINK_CLOCKS = CLK_FREQUENCY / (2 * BLINK_RATE);
  localparam int BL_W         = (BLINK_CLOCKS > 1) ? $clog2(BLINK_CLOCKS) : 1;

  logic [BL_W-1:0] blink_cnt;
  logic            blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BL_W'(BLINK_CLOCKS - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
    end
  end
`endif

  always_comb begin
    dark = blank[idx];
`ifdef SSD_BLINK_EN
    if (!blink_on && blink[idx]) dark = 1'b1;
`endif
    lit = !dark && (phase <= bright_q);
  end

  always_ff @(posedge clk) begin
    if (rst)      anode <= '1;
    else if (lit) anode <= ~(NUM_DIGITS'(1) << idx);
    else          anode <= '1;
  end

  seven_segment_decoder u_decoder (
    .clk     (clk),
    .rst     (rst),
    .enable  (lit),
    .nibble  (data_in[{idx, 2'b00} +: 4]),
    .dp      (dp_in[idx]),
    .segment (segment)
  );

endmodule

// File: tb/tb_seven_segment_mux.sv
// Randomized self-checking bench for seven_segment_mux against a cycle-count reference model.
// Blink stimulus and checks are included when SSD_BLINK_EN is defined.
module tb_seven_segment_mux;

  localparam int ND      = 8;
  localparam int CLK_HZ  = 100_000_000;
  localparam int REFRESH = 390_625;
  localparam int BLINK_HZ = 1_000_000;
  localparam int SEG      = CLK_HZ / (REFRESH * ND);  // 32
  localparam int PH       = SEG / 16;                 // 2
  localparam int BLINK_CLKS = CLK_HZ / (2 * BLINK_HZ);  // 50

  logic            clk = 1'b0;
  logic            rst;
  logic [4*ND-1:0] data_in;
  logic [ND-1:0]   blank;
  logic [ND-1:0]   dp_in;
  logic [3:0]      brightness;
  logic [ND-1:0]   blink;
  logic [7:0]      segment;
  logic [ND-1:0]   anode;

  seven_segment_mux #(
    .NUM_DIGITS    (ND),
    .CLK_FREQUENCY (CLK_HZ),
    .REFRESH_RATE  (REFRESH),
    .BLINK_RATE    (BLINK_HZ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .blank      (blank),
    .dp_in      (dp_in),
    .brightness (brightness),
`ifdef SSD_BLINK_EN
    .blink      (blink),
`endif
    .segment    (segment),
    .anode      (anode)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned m = 0;          // clocks since reset release
  int unsigned lit_cycles = 0;
  logic [3:0]  slot_bright = 4'hF;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (m=%0d)", tag, got, exp, m);
    end
  endtask

  // One clock: predict the registered outputs from the elapsed-cycle count, then compare.
  task automatic tick();
    int unsigned cnt, dig, ph;
    logic        dark, on;
    logic [7:0]  ea, es;
    logic [3:0]  nib;
    on = 1'b0;
    ea = 8'hFF;
    es = 8'hFF;
    if (!rst) begin
      cnt = m % SEG;
      dig = (m / SEG) % ND;
      if (cnt == 0) slot_bright = brightness;
      ph = cnt / PH;
      if (ph > 15) ph = 15;
      dark = blank[dig];
`ifdef SSD_BLINK_EN
      if (blink[dig] && ((m / BLINK_CLKS) % 2 == 1)) dark = 1'b1;
`endif
      on = !dark && (ph <= slot_bright);
      if (on) begin
        nib = data_in[4*dig +: 4];
        ea  = 8'(255 - (1 << dig));
        es  = {~dp_in[dig], glyph[nib]};
      end
    end
    @(posedge clk);
    #1;
    check_eq("anode", anode, ea);
    check_eq("segment", segment, es);
    check_eq("one_anode_low", ($countones(~anode) <= 1), 1);
    if (on) lit_cycles++;
    m = rst ? 0 : m + 1;
  endtask

  task automatic run(input int unsigned n, input bit randomize_data);
    for (int unsigned i = 0; i < n; i++) begin
      if (randomize_data) begin
        data_in = $urandom;
        if ($urandom_range(7) == 0) dp_in = 8'($urandom);
        if ($urandom_range(15) == 0) blank = 8'($urandom) & 8'($urandom);
        if ($urandom_range(40) == 0) brightness = 4'($urandom);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 32'h0123_4567; blank = '0; dp_in = '0;
    brightness = 4'hF; blink = '0;
    #1;
    tick(); tick();

    // Full brightness sweep over all digits.
    rst = 1'b0;
    lit_cycles = 0;
    run(ND * SEG, 0);
    check_eq("lit_full", lit_cycles, ND * SEG);

    // PWM duty at brightness 0 and 7 over whole frames.
    brightness = 4'd0; lit_cycles = 0;
    run(ND * SEG, 0);
    check_eq("lit_b0", lit_cycles, ND * 2);
    brightness = 4'd7; lit_cycles = 0;
    run(ND * SEG, 0);
    check_eq("lit_b7", lit_cycles, ND * 16);

    // Mid-slot brightness change must only apply from the next slot.
    brightness = 4'hF;
    run(10, 0);
    check_eq("slot_pos", m % SEG, 10);
    brightness = 4'd2; lit_cycles = 0;
    run(SEG - 10, 0);
    check_eq("lit_old_duty", lit_cycles, SEG - 10);
    lit_cycles = 0;
    run(SEG, 0);
    check_eq("lit_new_duty", lit_cycles, 3 * PH);

    // Blanked digits 0 and 7, decimal points on even digits.
    brightness = 4'hF; blank = 8'b1000_0001; dp_in = 8'h55; lit_cycles = 0;
    while (m % (ND * SEG) != 0) tick();
    lit_cycles = 0;
    run(ND * SEG, 0);
    check_eq("lit_blank", lit_cycles, 6 * SEG);

    // Glyphs 8..F.
    blank = '0; dp_in = '0; data_in = 32'h89AB_CDEF;
    run(ND * SEG, 0);

    // Randomized data, dp, blank and brightness.
    run(3000, 1);

    // Reset mid-slot on digit 5.
    blank = '0; brightness = 4'hF;
    for (int unsigned i = 0; i < 2 * ND * SEG; i++) begin
      if ((m / SEG) % ND == 5 && m % SEG == 13) break;
      tick();
    end
    check_eq("reached_digit5", (m / SEG) % ND, 5);
    rst = 1'b1;
    tick();
    check_eq("rst_anode", anode, 8'hFF);
    tick();
    rst = 1'b0;
    tick();
    check_eq("first_digit_after_rst", anode, 8'hFE);
    run(2 * SEG, 1);

`ifdef SSD_BLINK_EN
    // Blink digit 1; blink phase restarts with reset so align by resetting.
    rst = 1'b1; blank = '0; brightness = 4'hF;
    tick();
    rst = 1'b0; blink = 8'h02;
    run(4 * ND * SEG, 1);
    blink = 8'($urandom);
    run(2000, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
